// File: rtl/nand_gate_tester.sv
// ============================================================================
// Module   : nand_gate_tester
// Brief    : Drives a 2-input NAND under test through its truth table, checks
//            the responses and reports errors via a start/busy/done handshake.
//            Optional macro NAND_GATE_TESTER_STOP_ON_FAIL_EN ends a run at the
//            first mismatch.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nand_gate_tester #(
    parameter int         SETTLE_CYCLES = 2,
    parameter int         PASSES        = 1,
    parameter logic [3:0] EXPECT        = 4'b0111,
    parameter int         ERR_W         = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic             dut_y_in,
    output logic             a_out,
    output logic             b_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             pass_out,
    output logic [ERR_W-1:0] err_cnt_out,
    output logic [3:0]       fail_vec_out
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [7:0]       c_settle_last = 8'(SETTLE_CYCLES);
    localparam logic [7:0]       c_pass_last   = 8'(PASSES - 1);
    localparam logic [ERR_W-1:0] c_err_max     = '1;

    logic [1:0]       r_state;
    logic [7:0]       r_settle_cnt;
    logic [7:0]       r_pass_cnt;
    logic [1:0]       r_vec;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err_cnt;
    logic [3:0]       r_fail_vec;

    logic             w_sample;
    logic             w_mismatch;
    logic             w_sweep_end;
    logic             w_last;
    logic [ERR_W-1:0] w_err_next;

    // A sample edge is the last edge of the current vector's hold window.
    assign w_sample    = (r_state == c_st_run) && (r_settle_cnt == c_settle_last);
    assign w_mismatch  = w_sample && (dut_y_in != EXPECT[r_vec]);
    assign w_sweep_end = w_sample && (r_vec == 2'd3) && (r_pass_cnt == c_pass_last);
    assign w_err_next  = (w_mismatch && (r_err_cnt != c_err_max))
                       ? r_err_cnt + ERR_W'(1) : r_err_cnt;

`ifdef NAND_GATE_TESTER_STOP_ON_FAIL_EN
    assign w_last = w_sweep_end || w_mismatch;
`else
    assign w_last = w_sweep_end;
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state      <= c_st_idle;
            r_settle_cnt <= 8'd0;
            r_pass_cnt   <= 8'd0;
            r_vec        <= 2'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_cnt    <= '0;
            r_fail_vec   <= 4'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (start_in) begin
                        r_state      <= c_st_run;
                        r_busy       <= 1'b1;
                        r_vec        <= 2'd0;
                        r_settle_cnt <= 8'd0;
                        r_pass_cnt   <= 8'd0;
                        r_err_cnt    <= '0;
                        r_fail_vec   <= 4'd0;
                        r_pass       <= 1'b0;
                    end else begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_run: begin
                    if (w_sample) begin
                        r_err_cnt <= w_err_next;
                        if (w_mismatch) begin
                            r_fail_vec[r_vec] <= 1'b1;
                        end
                        if (w_last) begin
                            r_state <= c_st_done;
                            r_busy  <= 1'b0;
                            r_vec   <= 2'd0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                        end else begin
                            r_vec        <= r_vec + 2'd1;
                            r_settle_cnt <= 8'd0;
                            if (r_vec == 2'd3) begin
                                r_pass_cnt <= r_pass_cnt + 8'd1;
                            end
                        end
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign a_out        = r_vec[1];
    assign b_out        = r_vec[0];
    assign busy_out     = r_busy;
    assign done_out     = r_done;
    assign pass_out     = r_pass;
    assign err_cnt_out  = r_err_cnt;
    assign fail_vec_out = r_fail_vec;

endmodule

`default_nettype wire

// File: tb/tb_nand_gate_tester.sv
// ============================================================================
// Module   : tb_nand_gate_tester
// Brief    : Self-checking bench for nand_gate_tester using randomised gate
//            truth tables and a behavioural model of the expected results.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nand_gate_tester;

`ifdef NAND_GATE_TESTER_STOP_ON_FAIL_EN
    localparam bit c_stop = 1'b1;
`else
    localparam bit c_stop = 1'b0;
`endif
    localparam int c_hold = 3;   // SETTLE_CYCLES + 1 of the main instance

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] tbl_main = 4'b0111;
    logic       a_m, b_m, busy_m, done_m, pass_m;
    logic [7:0] err_m;
    logic [3:0] fail_m;
    logic       y_main;

    logic       start2 = 1'b0;
    logic [3:0] tbl_sat = 4'b1000;
    logic       a_s, b_s, busy_s, done_s, pass_s;
    logic [1:0] err_s;
    logic [3:0] fail_s;
    logic       y_sat;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] obs_ab   [64];
    logic       obs_busy [64];
    logic [7:0] obs_err  [64];
    int         obs_done_at;
    logic [7:0] fin_err;
    logic [3:0] fin_fail;
    logic       fin_pass;
    logic [1:0] fin_ab;
    logic       fin_busy;

    always #5 clk = ~clk;

    assign y_main = tbl_main[{a_m, b_m}];
    assign y_sat  = tbl_sat[{a_s, b_s}];

    nand_gate_tester u_dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .dut_y_in(y_main),
        .a_out(a_m), .b_out(b_m), .busy_out(busy_m), .done_out(done_m),
        .pass_out(pass_m), .err_cnt_out(err_m), .fail_vec_out(fail_m)
    );

    nand_gate_tester #(.SETTLE_CYCLES(0), .PASSES(2), .ERR_W(2)) u_sat (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start2), .dut_y_in(y_sat),
        .a_out(a_s), .b_out(b_s), .busy_out(busy_s), .done_out(done_s),
        .pass_out(pass_s), .err_cnt_out(err_s), .fail_vec_out(fail_s)
    );

    function automatic logic nand_of(input int v);
        return !(((v / 2) % 2 == 1) && (v % 2 == 1));
    endfunction

    // Expected outcome of one run: vectors applied, error count, flags, verdict.
    function automatic void model(input logic [3:0] tbl, input int npass, input int errmax,
                                  output int nvec, output int err,
                                  output logic [3:0] fail, output logic pass);
        nvec = 0; err = 0; fail = 4'd0;
        for (int k = 0; k < 4 * npass; k++) begin
            nvec++;
            if (tbl[k % 4] != nand_of(k % 4)) begin
                if (err < errmax) err++;
                fail[k % 4] = 1'b1;
                if (c_stop) break;
            end
        end
        pass = (err == 0);
    endfunction

    task automatic run_main(input logic [3:0] tbl);
        tbl_main = tbl;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        obs_done_at = -1;
        for (int t = 0; t < 64; t++) begin
            if (t > 0) @(negedge clk);
            obs_ab[t] = {a_m, b_m}; obs_busy[t] = busy_m; obs_err[t] = err_m;
            if (done_m) begin
                obs_done_at = t;
                fin_err = err_m; fin_fail = fail_m; fin_pass = pass_m;
                fin_ab = {a_m, b_m}; fin_busy = busy_m;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({a_m, b_m, busy_m, done_m, pass_m, err_m, fail_m} !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_main: got %b required 0", {a_m, b_m, busy_m, done_m, pass_m, err_m, fail_m});
        end
        n_cmp++;
        if ({a_s, b_s, busy_s, done_s, pass_s, err_s, fail_s} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_sat: got %b required 0", {a_s, b_s, busy_s, done_s, pass_s, err_s, fail_s});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_tables();
        logic [3:0] tbls [8];
        int nvec, e_err, e_cnt;
        logic [3:0] e_fail;
        logic e_pass;
        tbls[0] = 4'b0111; tbls[1] = 4'b1111; tbls[2] = 4'b0000; tbls[3] = 4'b1000;
        for (int i = 4; i < 8; i++) tbls[i] = 4'($urandom_range(0, 15));
        for (int i = 0; i < 8; i++) begin
            model(tbls[i], 1, 255, nvec, e_err, e_fail, e_pass);
            run_main(tbls[i]);
            n_cmp++;
            if (obs_done_at !== nvec * c_hold) begin
                n_bad++;
                $display("FAIL done_time tbl=%b: got %0d required %0d", tbls[i], obs_done_at, nvec * c_hold);
            end
            if (obs_done_at < 0) continue;
            n_cmp++;
            if ({fin_err, fin_fail, fin_pass} !== {8'(e_err), e_fail, e_pass}) begin
                n_bad++;
                $display("FAIL result tbl=%b: got err=%0d fail=%b pass=%b required err=%0d fail=%b pass=%b",
                         tbls[i], fin_err, fin_fail, fin_pass, e_err, e_fail, e_pass);
            end
            n_cmp++;
            if ({fin_ab, fin_busy} !== 3'b000) begin
                n_bad++;
                $display("FAIL done_idle tbl=%b: got ab=%b busy=%b required 00/0", tbls[i], fin_ab, fin_busy);
            end
            for (int t = 0; t < obs_done_at; t++) begin
                e_cnt = 0;
                for (int k = 0; k < t / c_hold; k++)
                    if (tbls[i][k % 4] != nand_of(k % 4)) e_cnt++;
                n_cmp++;
                if ({obs_ab[t], obs_busy[t], obs_err[t]} !== {2'((t / c_hold) % 4), 1'b1, 8'(e_cnt)}) begin
                    n_bad++;
                    $display("FAIL trace tbl=%b t=%0d: got ab=%b busy=%b err=%0d required ab=%b busy=1 err=%0d",
                             tbls[i], t, obs_ab[t], obs_busy[t], obs_err[t], 2'((t / c_hold) % 4), e_cnt);
                end
            end
            @(negedge clk);
            n_cmp++;
            if ({done_m, busy_m, err_m, fail_m, pass_m} !== {2'b00, 8'(e_err), e_fail, e_pass}) begin
                n_bad++;
                $display("FAIL hold tbl=%b: got done=%b busy=%b err=%0d fail=%b pass=%b",
                         tbls[i], done_m, busy_m, err_m, fail_m, pass_m);
            end
        end
    endtask

    task automatic test_saturation();
        int nvec, e_err, got_at;
        logic [3:0] e_fail;
        logic e_pass;
        for (int i = 0; i < 3; i++) begin
            tbl_sat = (i == 0) ? 4'b1000 : 4'($urandom_range(0, 15));
            model(tbl_sat, 2, 3, nvec, e_err, e_fail, e_pass);
            @(negedge clk); start2 = 1'b1;
            @(negedge clk); start2 = 1'b0;
            got_at = -1;
            for (int t = 0; t < 40; t++) begin
                if (t > 0) @(negedge clk);
                if (done_s) begin got_at = t; break; end
            end
            n_cmp++;
            if (got_at !== nvec) begin
                n_bad++;
                $display("FAIL sat_done tbl=%b: got %0d required %0d", tbl_sat, got_at, nvec);
            end
            n_cmp++;
            if ({err_s, fail_s, pass_s} !== {2'(e_err), e_fail, e_pass}) begin
                n_bad++;
                $display("FAIL sat_result tbl=%b: got err=%0d fail=%b pass=%b required err=%0d fail=%b pass=%b",
                         tbl_sat, err_s, fail_s, pass_s, e_err, e_fail, e_pass);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_done, last_at;
        tbl_main = 4'b0111;
        n_done = 0; last_at = -1;
        @(negedge clk); start = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (done_m) begin
                n_cmp++;
                if (t != 12 + 13 * n_done) begin
                    n_bad++;
                    $display("FAIL b2b_spacing: got done at %0d required %0d", t, 12 + 13 * n_done);
                end
                n_done++;
                last_at = t;
            end
        end
        n_cmp++;
        if (n_done !== 3) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d required 3 (last at %0d)", n_done, last_at);
        end
        start = 1'b0;
        repeat (20) @(negedge clk);
        // A start pulse in the middle of a run must not disturb it.
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        obs_done_at = -1;
        for (int t = 5; t < 30; t++) begin
            if (done_m) begin obs_done_at = t; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (obs_done_at !== 12) begin
            n_bad++;
            $display("FAIL start_in_run: got done at %0d required 12", obs_done_at);
        end
        @(negedge clk);
        n_cmp++;
        if ({busy_m, done_m} !== 2'b00) begin
            n_bad++;
            $display("FAIL start_in_run_idle: got busy=%b done=%b required 0/0", busy_m, done_m);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen_done;
        tbl_main = 4'b0111;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++;
        if ({a_m, b_m} !== 2'b10) begin
            n_bad++;
            $display("FAIL mid_run_vector: got %b required 10", {a_m, b_m});
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if ({a_m, b_m, busy_m, done_m, pass_m, err_m, fail_m} !== 17'd0) begin
            n_bad++;
            $display("FAIL mid_run_reset: got %b required 0", {a_m, b_m, busy_m, done_m, pass_m, err_m, fail_m});
        end
        seen_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_m || busy_m) seen_done++;
        end
        n_cmp++;
        if (seen_done !== 0) begin
            n_bad++;
            $display("FAIL mid_run_no_done: got %0d active cycles required 0", seen_done);
        end
        run_main(4'b0111);
        n_cmp++;
        if ({obs_done_at, fin_pass, fin_err, fin_fail} !== {32'sd12, 1'b1, 8'd0, 4'd0}) begin
            n_bad++;
            $display("FAIL after_reset_run: got done_at=%0d pass=%b err=%0d fail=%b required 12/1/0/0000",
                     obs_done_at, fin_pass, fin_err, fin_fail);
        end
    endtask

    initial begin
        test_reset();
        test_tables();
        test_saturation();
        test_back_to_back();
        test_reset_mid_run();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
